// File: rtl/nibble_sched_pkg.sv
// Shared types and defaults for the round-robin nibble adder scheduler.
package nibble_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } sched_state_t;

  localparam int N_REQ_DEF = 4;
  localparam int W_DEF     = 4;

endpackage

// File: rtl/nibble_add_unit.sv
// Registered W-bit adder producing a W+1 bit sum; updates only when load is high.
module nibble_add_unit #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W:0]   sum
);

  logic [W:0] sum_p1;

  // Stage p1: carry-extended sum register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_p1 <= '0;
    end else if (load) begin
      sum_p1 <= {1'b0, a} + {1'b0, b};
    end
  end

  assign sum = sum_p1;

endmodule

// File: rtl/nibble_add_sched.sv
// Round-robin arbiter sequencing requester operand pairs through one shared
// registered adder and returning the tagged sum on a backpressured port.
module nibble_add_sched
  import nibble_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int W     = W_DEF,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [W:0]         rsp_sum,
  output logic               busy
);

  sched_state_t   state_q;
  logic [IDW-1:0] rr_ptr_q;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] idx;
  logic           found;
  logic [W-1:0]   a_sel;
  logic [W-1:0]   b_sel;

  logic [W-1:0]   a_p0;
  logic [W-1:0]   b_p0;
  logic [IDW-1:0] id_p0;
  logic           vld_p1;
  logic           busy_q;

  // Scan downward so the requester closest to rr_ptr (smallest offset) wins;
  // IDW-bit addition wraps modulo N_REQ because N_REQ is a power of two.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = rr_ptr_q + IDW'(k);
      if (req_valid[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && found) begin
      req_ready[grant] = 1'b1;
    end
  end

  always_comb begin
    a_sel = req_a[grant*W +: W];
    b_sel = req_b[grant*W +: W];
  end

  // Stage p0: operand capture and scheduler state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      a_p0     <= '0;
      b_p0     <= '0;
      id_p0    <= '0;
      vld_p1   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            a_p0    <= a_sel;
            b_p0    <= b_sel;
            id_p0   <= grant;
            state_q <= EXEC;
            busy_q  <= 1'b1;
          end
        end
        EXEC: begin
          state_q <= RESP;
          vld_p1  <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            rr_ptr_q <= id_p0 + IDW'(1);
            vld_p1   <= 1'b0;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          vld_p1  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Stage p1: shared adder, loaded only during EXEC so RESP holds it frozen
  nibble_add_unit #(
    .W (W)
  ) u_add (
    .clk   (clk),
    .reset (reset),
    .load  (state_q == EXEC),
    .a     (a_p0),
    .b     (b_p0),
    .sum   (rsp_sum)
  );

  assign rsp_valid = vld_p1;
  assign rsp_id    = id_p0;
  assign busy      = busy_q;

endmodule
